// File: rtl/dcr_pkg.sv
// Shared constants, FSM encoding and CRC-16/CCITT-FALSE step function for the DCR transmitter and receiver.
package dcr_pkg;

  localparam int unsigned CRC_W  = 16;
  localparam int unsigned SYNC_W = 8;

  localparam logic [CRC_W-1:0]  CRC_POLY  = 16'h1021;
  localparam logic [CRC_W-1:0]  CRC_INIT  = 16'hFFFF;
  localparam logic [SYNC_W-1:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DONE    = 3'd4
  } dcr_state_e;

  // One serial CRC step: MSB-first, no reflection.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic             bit_in);
    logic fb;
    fb = crc[CRC_W-1] ^ bit_in;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Single-bit CRC-16/CCITT-FALSE engine; clr reloads the init value and has priority over en.
module crc16_serial
  import dcr_pkg::*;
(
  input  logic             clck,
  input  logic             start_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clck or negedge start_n) begin
    if (!start_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/dcr_frame_tx.sv
// Serial frame transmitter: [sync byte] + payload + CRC-16, MSB first, one bit per clock.
// Define DCR_TX_SYNC_EN to prepend the 8'hA5 sync byte (not covered by the CRC).
module dcr_frame_tx
  import dcr_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clck,
  input  logic                 start_n,
  input  logic [PAYLOAD_W-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 x,
  output logic                 x_valid,
  output logic                 busy,
  output logic                 done
);

  localparam logic [CNT_W-1:0] CNT_PAY = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] CNT_CRC = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef DCR_TX_SYNC_EN
  localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(SYNC_W - 1);
`endif

  dcr_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] shreg_q, shreg_d;
  logic                 x_q, x_d;
  logic                 x_valid_q, x_valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 crc_clr;
  logic                 crc_en;
  logic [CRC_W-1:0]     crc_val;
  logic [CRC_W-1:0]     crc_nxt;
  logic [3:0]           crc_idx;
`ifdef DCR_TX_SYNC_EN
  logic [2:0]           sync_idx;
`endif

  // The bit currently on x is folded into the CRC during its own cycle.
  crc16_serial u_crc (
    .clck    (clck),
    .start_n (start_n),
    .clr     (crc_clr),
    .en      (crc_en),
    .bit_in  (x_q),
    .crc     (crc_val)
  );

  // Lookahead so the first CRC bit can be registered on the last payload edge.
  assign crc_nxt = crc16_step(crc_val, x_q);
  assign crc_idx = cnt_q[3:0] - 4'd1;
`ifdef DCR_TX_SYNC_EN
  assign sync_idx = cnt_q[2:0] - 3'd1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          shreg_d   = data_in;
          crc_clr   = 1'b1;
          x_valid_d = 1'b1;
`ifdef DCR_TX_SYNC_EN
          state_d   = ST_SYNC;
          cnt_d     = CNT_SYNC;
          x_d       = SYNC_BYTE[SYNC_W-1];
`else
          state_d   = ST_PAYLOAD;
          cnt_d     = CNT_PAY;
          x_d       = data_in[PAYLOAD_W-1];
`endif
        end
      end
`ifdef DCR_TX_SYNC_EN
      ST_SYNC: begin
        x_valid_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_PAYLOAD;
          cnt_d   = CNT_PAY;
          x_d     = shreg_q[PAYLOAD_W-1];
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          x_d   = SYNC_BYTE[sync_idx];
        end
      end
`endif
      ST_PAYLOAD: begin
        crc_en    = 1'b1;
        x_valid_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_CRC;
          cnt_d   = CNT_CRC;
          x_d     = crc_nxt[CRC_W-1];
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          shreg_d = {shreg_q[PAYLOAD_W-2:0], 1'b0};
          x_d     = shreg_q[PAYLOAD_W-2];
        end
      end
      ST_CRC: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          x_valid_d = 1'b1;
          cnt_d     = cnt_q - CNT_ONE;
          x_d       = crc_val[crc_idx];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clck or negedge start_n) begin
    if (!start_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign data_ready = (state_q == ST_IDLE);
  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dcr_frame_tx.sv
// Self-checking bench for dcr_frame_tx: per-cycle comparison against a queue-based frame model.
module tb_dcr_frame_tx;

  localparam int unsigned PW = 72;
`ifdef DCR_TX_SYNC_EN
  localparam int unsigned SYNC_BITS = 8;
`else
  localparam int unsigned SYNC_BITS = 0;
`endif
  localparam int unsigned FRAME_LEN = SYNC_BITS + PW + 16;
  localparam int unsigned PERIOD    = FRAME_LEN + 2;

  logic          clck;
  logic          start_n;
  logic [PW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic          x;
  logic          x_valid;
  logic          busy;
  logic          done;

  dcr_frame_tx #(.PAYLOAD_W(PW), .CNT_W(8)) dut (
    .clck       (clck),
    .start_n    (start_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one entry per output cycle. 2'b1b = frame bit b, 2'b01 = done cycle, 2'b00 = idle.
  logic [1:0] cur;
  logic [1:0] q[$];
  bit         last_xfer;
  int         n_xfer;

  int          vcnt;
  logic [15:0] cap_tail;
  logic [7:0]  cap_head;

  function automatic logic [15:0] model_crc(input logic [127:0] d, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic enqueue(input logic [PW-1:0] d);
    logic [15:0] c;
    logic [7:0]  sb;
    c  = model_crc({56'b0, d}, PW);
    sb = 8'hA5;
    for (int i = int'(SYNC_BITS) - 1; i >= 0; i--) q.push_back({1'b1, sb[i]});
    for (int i = PW - 1; i >= 0; i--) q.push_back({1'b1, d[i]});
    for (int i = 15; i >= 0; i--) q.push_back({1'b1, c[i]});
    q.push_back(2'b01);
  endtask

  // One clock: compare current outputs, drive next inputs, advance the model.
  task automatic step(input logic v, input logic [PW-1:0] d);
    @(negedge clck);
    check1("x_valid", 32'(x_valid), 32'(cur[1]));
    check1("x", 32'(x), 32'(cur == 2'b11));
    check1("done", 32'(done), 32'(cur == 2'b01));
    check1("busy", 32'(busy), 32'(cur != 2'b00));
    check1("data_ready", 32'(data_ready), 32'(cur == 2'b00));
    if (x_valid) begin
      vcnt++;
      cap_tail = {cap_tail[14:0], x};
      if (vcnt <= 8) cap_head = {cap_head[6:0], x};
    end
    data_valid = v;
    data_in    = d;
    last_xfer  = (cur == 2'b00) && v;
    if (last_xfer) begin
      n_xfer++;
      enqueue(d);
    end
    cur = (q.size() != 0) ? q.pop_front() : 2'b00;
  endtask

  task automatic clear_cap();
    vcnt = 0; cap_tail = '0; cap_head = '0;
  endtask

  function automatic logic [PW-1:0] rand_word();
    return PW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic check_reset_outputs(input string tag);
    check1({tag, "_x"}, 32'(x), 32'd0);
    check1({tag, "_x_valid"}, 32'(x_valid), 32'd0);
    check1({tag, "_busy"}, 32'(busy), 32'd0);
    check1({tag, "_done"}, 32'(done), 32'd0);
    check1({tag, "_data_ready"}, 32'(data_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] pd;
    logic          pv;
    logic [PW-1:0] saved;

    start_n = 1'b0; data_valid = 1'b0; data_in = '0;
    cur = 2'b00; last_xfer = 1'b0; n_xfer = 0;
    clear_cap();

    // Model pins against published CRC-16/CCITT-FALSE check values.
    check1("pin_crc_123456789", 32'(model_crc(128'h313233343536373839, 72)), 32'h29B1);
    check1("pin_crc_A", 32'(model_crc(128'h41, 8)), 32'hB915);

    repeat (3) @(negedge clck);
    check_reset_outputs("reset");
    start_n = 1'b1;

    // Known-answer frame "123456789".
    clear_cap();
    step(1'b1, 72'h313233343536373839);
    repeat (FRAME_LEN + 3) step(1'b0, '0);
    check1("kat_len", 32'(vcnt), 32'(FRAME_LEN));
    check1("kat_crc", 32'(cap_tail), 32'h29B1);
`ifdef DCR_TX_SYNC_EN
    check1("kat_sync", 32'(cap_head), 32'hA5);
`endif

    // All-zero payload; CRC must exclude any sync prefix.
    clear_cap();
    step(1'b1, '0);
    repeat (FRAME_LEN + 3) step(1'b0, '0);
    check1("zero_len", 32'(vcnt), 32'(FRAME_LEN));
    check1("zero_crc", 32'(cap_tail), 32'(model_crc(128'h0, 72)));
`ifdef DCR_TX_SYNC_EN
    check1("zero_sync", 32'(cap_head), 32'hA5);
`else
    check1("zero_head", 32'(cap_head), 32'h00);
`endif

    // data_valid held high: exactly one transfer per frame period.
    n_xfer = 0;
    pd = rand_word();
    for (int i = 0; i < int'(3 * PERIOD); i++) begin
      if (last_xfer) pd = rand_word();
      step(1'b1, pd);
    end
    check1("held_valid_xfers", 32'(n_xfer), 32'd3);
    repeat (FRAME_LEN + 3) step(1'b0, '0);

    // Randomized traffic; data holds until accepted.
    pv = 1'b0; pd = '0;
    for (int i = 0; i < 600; i++) begin
      if (last_xfer || !pv) begin
        pv = ($urandom_range(0, 2) != 0);
        pd = rand_word();
      end
      step(pv, pd);
    end
    repeat (FRAME_LEN + 3) step(1'b0, '0);

    // Reset asserted at payload bit 10 aborts the frame at once.
    saved = rand_word();
    step(1'b1, saved);
    repeat (SYNC_BITS + 10) step(1'b0, '0);
    check1("pre_abort_busy", 32'(busy), 32'd1);
    @(posedge clck);
    #2 start_n = 1'b0;
    #1 check_reset_outputs("abort");
    cur = 2'b00; q.delete(); data_valid = 1'b0; last_xfer = 1'b0;
    @(negedge clck);
    #1 start_n = 1'b1;
    repeat (3) step(1'b0, '0);

    // Full frame after release.
    clear_cap();
    step(1'b1, saved);
    repeat (FRAME_LEN + 3) step(1'b0, '0);
    check1("post_abort_len", 32'(vcnt), 32'(FRAME_LEN));
    check1("post_abort_crc", 32'(cap_tail), 32'(model_crc({56'b0, saved}, 72)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
